// File: rtl/cpu_mem_pkg.sv
// Shared MEM-stage definitions: FSM encoding, bus width defaults, timeout fill value.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_mem_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int ADDR_W_DEF  = 16;
  localparam int TIMEOUT_DEF = 64;

  // A timed-out load returns all ones so MEM/WB sees an obviously bogus value.
  localparam logic FILL_BIT = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    DONE    = 2'd3
  } mem_state_t;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Bus-wait watchdog: counts enabled cycles, flags expire on the LIMIT-th one.
// Latency: expire is combinational from the count; clear takes effect next cycle.
// Backpressure: none; holds at LIMIT-1 while enable stays high.
module mem_timeout_cnt #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = ($clog2(LIMIT) > 0) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] cnt;

  assign expire = enable && (cnt == CW'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expire) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory controller: load/store -> registered req/ack bus cycle, stalls upstream while busy.
// Latency: load = issue + >=1 wait + DONE (3 cycles min); non-memory ops pass with zero latency.
// Backpressure: stall held through issue and wait states; MEM_BUS_TIMEOUT_EN adds a wait-cycle watchdog.
module mem_access_ctrl
  import cpu_mem_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEF,
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              stall,
  output logic              read,
  output logic              read_ready,
  output logic [DATA_W-1:0] memout,
  output logic              bus_err
);

  mem_state_t        state, state_nxt;
  logic              req_nxt, we_nxt, read_nxt, rr_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] wdata_nxt, memout_nxt;
  logic              tmo;

`ifdef MEM_BUS_TIMEOUT_EN
  logic wait_st;

  assign wait_st = (state == RD_WAIT) || (state == WR_WAIT);

  // Held in clear outside the wait states, so every transaction starts from zero.
  mem_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (!wait_st),
    .enable (wait_st),
    .expire (tmo)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_err <= 1'b0;
    end else begin
      bus_err <= tmo && !bus_ack;
    end
  end
`else
  assign tmo     = 1'b0;
  assign bus_err = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    req_nxt    = bus_req;
    we_nxt     = bus_we;
    addr_nxt   = bus_addr;
    wdata_nxt  = bus_wdata;
    memout_nxt = memout;
    read_nxt   = 1'b0;
    rr_nxt     = 1'b0;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        // Load wins when both flags are set; the store is dropped.
        if (in_valid && memread) begin
          stall     = 1'b1;
          state_nxt = RD_WAIT;
          req_nxt   = 1'b1;
          we_nxt    = 1'b0;
          addr_nxt  = addr;
          read_nxt  = 1'b1;
        end else if (in_valid && memwrite) begin
          stall     = 1'b1;
          state_nxt = WR_WAIT;
          req_nxt   = 1'b1;
          we_nxt    = 1'b1;
          addr_nxt  = addr;
          wdata_nxt = wdata;
        end
      end
      RD_WAIT: begin
        stall = 1'b1;
        if (bus_ack) begin
          memout_nxt = bus_rdata;
          req_nxt    = 1'b0;
          rr_nxt     = 1'b1;
          state_nxt  = DONE;
        end else if (tmo) begin
          memout_nxt = {DATA_W{FILL_BIT}};
          req_nxt    = 1'b0;
          rr_nxt     = 1'b1;
          state_nxt  = DONE;
        end
      end
      WR_WAIT: begin
        stall = 1'b1;
        if (bus_ack || tmo) begin
          req_nxt   = 1'b0;
          state_nxt = DONE;
        end
      end
      // in_valid still shows the finished op here; upstream advances at the end of this cycle.
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      read       <= 1'b0;
      read_ready <= 1'b0;
      memout     <= '0;
    end else begin
      state      <= state_nxt;
      bus_req    <= req_nxt;
      bus_we     <= we_nxt;
      bus_addr   <= addr_nxt;
      bus_wdata  <= wdata_nxt;
      read       <= read_nxt;
      read_ready <= rr_nxt;
      memout     <= memout_nxt;
    end
  end

endmodule
